// File: rtl/leg_mem_pkg.sv
// Shared types and constants for the LEG memory-bus arbiter.
package leg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER_I,
    XFER_D,
    TURN
  } arb_state_t;

  localparam int unsigned BEAT_BYTES = 4;

endpackage

// File: rtl/leg_mem_arbiter.sv
// Arbitrates the LEG core's I-side and D-side line bursts onto one memory bus.
// D has priority; a streak counter forces an I grant after MAX_D_STREAK D grants.
module leg_mem_arbiter
  import leg_mem_pkg::*;
#(
  parameter int unsigned BEATS        = 4,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     IReq,
  input  logic [31:0]              IAddr,
  output logic [31:0]              IRdData,
  output logic                     IRdValid,
  output logic                     IDone,
  output logic                     IBusy,
  input  logic                     DReq,
  input  logic                     DWrite,
  input  logic [31:0]              DAddr,
  input  logic [31:0]              DWrData,
  output logic [$clog2(BEATS)-1:0] DBeat,
  output logic [31:0]              DRdData,
  output logic                     DRdValid,
  output logic                     DDone,
  output logic                     DBusy,
  output logic                     BusValid,
  output logic                     BusWrite,
  output logic [31:0]              BusAddr,
  output logic [31:0]              BusWrData,
  input  logic                     BusReady,
  input  logic [31:0]              BusRdData
);

  localparam int unsigned BeatW   = $clog2(BEATS);
  localparam int unsigned OffW    = $clog2(BEAT_BYTES);
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [BeatW-1:0]   LastBeat  = BeatW'(BEATS - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  arb_state_t         state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               beat_fire;
  logic               last_fire;

  // Line-offset address bits are replaced by the beat counter.
  logic unused_addr;
  assign unused_addr = ^{IAddr[BeatW+OffW-1:0], DAddr[BeatW+OffW-1:0]};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    streak_d  = streak_q;
    IRdData   = '0;
    IRdValid  = 1'b0;
    IDone     = 1'b0;
    DBeat     = '0;
    DRdData   = '0;
    DRdValid  = 1'b0;
    DDone     = 1'b0;
    BusValid  = 1'b0;
    BusWrite  = 1'b0;
    BusAddr   = '0;
    BusWrData = '0;
    IBusy     = IReq | (state_q == XFER_I);
    DBusy     = DReq | (state_q == XFER_D);
    beat_fire = 1'b0;
    last_fire = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (DReq && !(IReq && (streak_q == StreakMax))) begin
          state_d = XFER_D;
          if (!IReq) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (IReq) begin
          state_d  = XFER_I;
          streak_d = '0;
        end
      end
      XFER_I: begin
        BusValid  = 1'b1;
        BusAddr   = {IAddr[31:BeatW+OffW], beat_q, {OffW{1'b0}}};
        beat_fire = BusReady;
        last_fire = BusReady && (beat_q == LastBeat);
        IRdData   = BusRdData;
        IRdValid  = BusReady;
        IDone     = last_fire;
      end
      XFER_D: begin
        BusValid  = 1'b1;
        BusWrite  = DWrite;
        BusAddr   = {DAddr[31:BeatW+OffW], beat_q, {OffW{1'b0}}};
        BusWrData = DWrData;
        DBeat     = beat_q;
        beat_fire = BusReady;
        last_fire = BusReady && (beat_q == LastBeat);
        DRdData   = DWrite ? '0 : BusRdData;
        DRdValid  = BusReady && !DWrite;
        DDone     = last_fire;
      end
      TURN: begin
        state_d = IDLE;
      end
    endcase

    if (last_fire) begin
      beat_d  = '0;
      // A writeback leaves one dead bus cycle before the next owner drives.
      state_d = ((state_q == XFER_D) && DWrite) ? TURN : IDLE;
    end else if (beat_fire) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_leg_mem_arbiter.sv
// Self-checking bench for leg_mem_arbiter: per-cycle vector table plus burst-level sequences.
module tb_leg_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdData;
  logic        IRdValid;
  logic        IDone;
  logic        IBusy;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWrData;
  logic [1:0]  DBeat;
  logic [31:0] DRdData;
  logic        DRdValid;
  logic        DDone;
  logic        DBusy;
  logic        BusValid;
  logic        BusWrite;
  logic [31:0] BusAddr;
  logic [31:0] BusWrData;
  logic        BusReady;
  logic [31:0] BusRdData;

  int checks   = 0;
  int failures = 0;

  leg_mem_arbiter #(
    .BEATS       (4),
    .MAX_D_STREAK(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .IRdData  (IRdData),
    .IRdValid (IRdValid),
    .IDone    (IDone),
    .IBusy    (IBusy),
    .DReq     (DReq),
    .DWrite   (DWrite),
    .DAddr    (DAddr),
    .DWrData  (DWrData),
    .DBeat    (DBeat),
    .DRdData  (DRdData),
    .DRdValid (DRdValid),
    .DDone    (DDone),
    .DBusy    (DBusy),
    .BusValid (BusValid),
    .BusWrite (BusWrite),
    .BusAddr  (BusAddr),
    .BusWrData(BusWrData),
    .BusReady (BusReady),
    .BusRdData(BusRdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // flags = {BusValid, BusWrite, IRdValid, IDone, IBusy, DRdValid, DDone, DBusy}
  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwrite;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        bready;
    logic [31:0] brdata;
    logic [7:0]  flags;
    logic [1:0]  dbeat;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ireq, logic [31:0] iaddr, logic dreq, logic dwrite,
                              logic [31:0] daddr, logic [31:0] dwdata, logic bready,
                              logic [31:0] brdata, logic [7:0] flags, logic [1:0] dbeat,
                              logic [31:0] baddr, logic [31:0] bwdata, logic [31:0] irdata,
                              logic [31:0] drdata);
    vec_t v;
    v.ireq = ireq;   v.iaddr = iaddr;   v.dreq = dreq;     v.dwrite = dwrite;
    v.daddr = daddr; v.dwdata = dwdata; v.bready = bready; v.brdata = brdata;
    v.flags = flags; v.dbeat = dbeat;   v.baddr = baddr;   v.bwdata = bwdata;
    v.irdata = irdata; v.drdata = drdata;
    return v;
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Watches one burst; side 1=I, 2=D, 3=unknown, 0=no beat within the cycle bound.
  task automatic get_burst(output int side, output int nb, output logic [31:0] faddr);
    side  = 0;
    nb    = 0;
    faddr = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (BusValid && BusReady) begin
        if (side == 0) begin
          side  = DRdValid ? 2 : (IRdValid ? 1 : 3);
          faddr = BusAddr;
        end
        nb++;
      end
      if (IDone || DDone) break;
    end
  endtask

  task automatic race(input logic wr, input int gap);
    int   t_dd, t_i;
    logic first_d, seen;
    t_dd = -1; t_i = -1; first_d = 1'b0; seen = 1'b0;
    @(posedge clk); #1;
    IReq = 1'b1; IAddr = 32'h500; DReq = 1'b1; DWrite = wr; DAddr = 32'h600;
    BusReady = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (BusValid && !seen) begin
        seen    = 1'b1;
        first_d = (BusAddr == 32'h600) && (BusWrite == wr);
      end
      if (DDone && t_dd < 0) begin
        t_dd = n;
        DReq = 1'b0;
      end
      if (IRdValid && t_i < 0) t_i = n;
      if (IDone) begin
        IReq = 1'b0;
        break;
      end
    end
    check($sformatf("race%0d_d_first", wr), {159'd0, first_d}, 160'd1);
    check($sformatf("race%0d_ddone_seen", wr), {159'd0, t_dd >= 0}, 160'd1);
    check($sformatf("race%0d_i_gap", wr), 160'(t_i - t_dd), 160'(gap));
  endtask

  initial begin
    int          side, nb, bad;
    logic [31:0] fa;
    int          exp_side[5];

    reset = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWrite = 1'b0; DAddr = '0;
    DWrData = '0; BusReady = 1'b0; BusRdData = '0;

    // Test 1: single I fill, BusReady always high.
    vecs.push_back(mk(1, 'h104, 0, 0, 0, 0, 1, 'hA0, 8'b0000_1000, 0, 0,      0, 0,     0));
    vecs.push_back(mk(1, 'h104, 0, 0, 0, 0, 1, 'hA1, 8'b1010_1000, 0, 'h100, 0, 'hA1, 0));
    vecs.push_back(mk(1, 'h104, 0, 0, 0, 0, 1, 'hA2, 8'b1010_1000, 0, 'h104, 0, 'hA2, 0));
    vecs.push_back(mk(1, 'h104, 0, 0, 0, 0, 1, 'hA3, 8'b1010_1000, 0, 'h108, 0, 'hA3, 0));
    vecs.push_back(mk(1, 'h104, 0, 0, 0, 0, 1, 'hA4, 8'b1011_1000, 0, 'h10C, 0, 'hA4, 0));
    vecs.push_back(mk(0, 'h104, 0, 0, 0, 0, 1, 'hA5, 8'b0000_0000, 0, 0,      0, 0,     0));
    // Test 2: D writeback with BusReady toggling, then the TURN cycle.
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD0, 1, 0, 8'b0000_0001, 0, 0,       0,     0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD0, 1, 0, 8'b1100_0001, 0, 'h2000, 'hD0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD1, 0, 0, 8'b1100_0001, 1, 'h2004, 'hD1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD1, 1, 0, 8'b1100_0001, 1, 'h2004, 'hD1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD2, 0, 0, 8'b1100_0001, 2, 'h2008, 'hD2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD2, 1, 0, 8'b1100_0001, 2, 'h2008, 'hD2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD3, 0, 0, 8'b1100_0001, 3, 'h200C, 'hD3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h2000, 'hD3, 1, 0, 8'b1100_0011, 3, 'h200C, 'hD3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h2000, 0,     0, 0, 8'b0000_0000, 0, 0,       0,     0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0,     0, 0, 8'b0000_0000, 0, 0,       0,     0, 0));

    #12;
    check("reset_outputs",
          160'({BusValid, BusWrite, IRdValid, IDone, IBusy, DRdValid, DDone, DBusy, DBeat,
                BusAddr, BusWrData, IRdData, DRdData}), 160'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      IReq = vecs[i].ireq;   IAddr = vecs[i].iaddr;     DReq = vecs[i].dreq;
      DWrite = vecs[i].dwrite; DAddr = vecs[i].daddr;   DWrData = vecs[i].dwdata;
      BusReady = vecs[i].bready; BusRdData = vecs[i].brdata;
      @(negedge clk);
      // Address/data fields are only meaningful while their qualifier is expected high.
      check($sformatf("vec%0d", i),
            160'({BusValid, BusWrite, IRdValid, IDone, IBusy, DRdValid, DDone, DBusy, DBeat,
                  vecs[i].flags[7] ? BusAddr : 32'h0, vecs[i].flags[6] ? BusWrData : 32'h0,
                  vecs[i].flags[5] ? IRdData : 32'h0, vecs[i].flags[2] ? DRdData : 32'h0}),
            160'({vecs[i].flags, vecs[i].dbeat, vecs[i].baddr, vecs[i].bwdata,
                  vecs[i].irdata, vecs[i].drdata}));
      @(posedge clk); #1;
    end

    // Test 3: simultaneous requests, D fill then D writeback.
    race(1'b0, 2);
    race(1'b1, 3);

    // Test 4: starvation guard with both requests held continuously.
    @(posedge clk); #1;
    IReq = 1'b1; IAddr = 32'h700; DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h800;
    BusReady = 1'b1;
    exp_side = '{2, 2, 2, 1, 2};
    for (int k = 0; k < 5; k++) begin
      get_burst(side, nb, fa);
      check($sformatf("starve_side%0d", k), 160'(side), 160'(exp_side[k]));
      check($sformatf("starve_beats%0d", k), 160'(nb), 160'd4);
    end
    IReq = 1'b0; DReq = 1'b0;

    // Test 5: asynchronous reset during beat 2 of an I burst.
    @(posedge clk); #1;
    IReq = 1'b1; IAddr = 32'h300;
    side = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (BusValid && BusAddr == 32'h308) begin
        side = 1;
        break;
      end
    end
    check("rst_beat2_reached", 160'(side), 160'd1);
    #1 reset = 1'b0;
    #1 check("rst_async_drop", 160'({BusValid, IDone, IRdValid}), 160'd0);
    IReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (BusValid || IDone) bad++;
    end
    check("rst_quiet_after", 160'(bad), 160'd0);
    IReq = 1'b1; IAddr = 32'h304;
    get_burst(side, nb, fa);
    IReq = 1'b0;
    check("rst_restart_side", 160'(side), 160'd1);
    check("rst_restart_addr", 160'(fa), 160'h300);
    check("rst_restart_beats", 160'(nb), 160'd4);

    // Test 6: DReq dropped after beat 1 of a fill.
    @(posedge clk); #1;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h4008; BusReady = 1'b1; BusRdData = 32'hBEEF;
    side = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (BusValid && BusAddr == 32'h4004) begin
        side = 1;
        break;
      end
    end
    check("drop_beat1_reached", 160'(side), 160'd1);
    DReq = 1'b0;
    @(negedge clk);
    check("drop_beat2", 160'({BusValid, BusAddr, DRdValid, DBusy, DDone}),
          160'({1'b1, 32'h4008, 1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    check("drop_beat3", 160'({BusValid, BusAddr, DRdValid, DBusy, DDone}),
          160'({1'b1, 32'h400C, 1'b1, 1'b1, 1'b1}));
    @(negedge clk);
    check("drop_idle", 160'({BusValid, DRdValid, DBusy, DDone}), 160'd0);
    @(negedge clk);
    check("drop_no_regrant", 160'({BusValid, DRdValid, DBusy, DDone}), 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
